// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// AXI burst/response encodings and the alignment helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [2:0] off, input size_e size);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: store data/strobe placement onto the 64-bit bus
// and load data extraction with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  off,
    input  size_e       size,
    input  logic        zero_ext,
    input  logic [63:0] st_data,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    input  logic [63:0] rdata,
    output logic [63:0] ld_data
);

    logic [63:0] shifted;
    logic [7:0]  base_strb;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        base_strb = 8'hFF;
        ld_data   = '0;
        // Shifts past bit 63 simply fall off: boundary-crossing accesses are truncated.
        wdata     = st_data << {off, 3'b000};
        shifted   = rdata >> {off, 3'b000};
        case (size)
            SZ_B: begin
                base_strb = 8'h01;
                ld_data   = {{56{~zero_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                base_strb = 8'h03;
                ld_data   = {{48{~zero_ext & shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                base_strb = 8'h0F;
                ld_data   = {{32{~zero_ext & shifted[31]}}, shifted[31:0]};
            end
            default: begin
                base_strb = 8'hFF;
                ld_data   = shifted;
            end
        endcase
        wstrb = base_strb << off;
    end

endmodule

// File: rtl/lsu_axi.sv
// Memory-stage load/store unit issuing single-beat AXI reads and writes.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests complete with an error and no bus traffic.
module lsu_axi
    import lsu_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,

    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);

    state_e                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    size_e                 size_q;
    logic                  zext_q;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  misalign_trap;
    logic                  aw_done;
    logic                  w_done;
    logic                  unused_rlast;

    // Single-beat responses always carry rlast, so it carries no information here.
    assign unused_rlast = m_axi_rlast;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_trap = is_misaligned(req_addr[2:0], size_e'(req_size));
`else
    assign misalign_trap = 1'b0;
`endif

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = {1'b0, size_q};
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = {1'b0, size_q};
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_wlast   = 1'b1;

    // A channel counts as done once its valid has dropped or is handshaking now.
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid  || m_axi_wready;

    lsu_lane_align u_lane_align (
        .off      (addr_q[2:0]),
        .size     (size_q),
        .zero_ext (zext_q),
        .st_data  (wdata_q),
        .wdata    (m_axi_wdata),
        .wstrb    (m_axi_wstrb),
        .rdata    (m_axi_rdata),
        .ld_data  (ld_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            size_q        <= SZ_B;
            zext_q        <= 1'b0;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_ready && req_valid) begin
                        req_ready  <= 1'b0;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= size_e'(req_size);
                        zext_q     <= req_unsigned;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        if (misalign_trap) begin
                            resp_err <= 1'b1;
                            state    <= DONE;
                        end else if (req_write) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR_REQ;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        resp_err     <= (m_axi_rresp != RESP_OKAY);
                        resp_rdata   <= (m_axi_rresp == RESP_OKAY) ? ld_data : '0;
                        state        <= DONE;
                    end
                end
                WR_REQ: begin
                    if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        resp_err     <= (m_axi_bresp != RESP_OKAY);
                        state        <= DONE;
                    end
                end
                DONE: begin
                    resp_valid <= 1'b1;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi.sv
// Scoreboard bench for lsu_axi: a delay-configurable AXI slave, a reference model of the
// lane rules and latency, and a monitor that checks every resp_valid pulse.
module tb_lsu_axi;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    logic [12:0] m_axi_arid, m_axi_awid;
    logic [63:0] m_axi_araddr, m_axi_awaddr;
    logic [7:0]  m_axi_arlen, m_axi_awlen;
    logic [2:0]  m_axi_arsize, m_axi_awsize;
    logic [1:0]  m_axi_arburst, m_axi_awburst;
    logic        m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready;
    logic        m_axi_arready = 1'b0, m_axi_awready = 1'b0, m_axi_wready = 1'b0;
    logic [63:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0, m_axi_bresp = '0;
    logic        m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_bvalid = 1'b0;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast;

    lsu_axi dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_cyc = 0;
    int   resp_cnt = 0;

    // Slave configuration and expected bus contents for the current operation.
    logic [63:0] sl_rdata = '0;
    logic [1:0]  sl_rresp = '0, sl_bresp = '0;
    int          sl_ar_dly = 0, sl_aw_dly = 0, sl_w_dly = 0, sl_r_dly = 0;
    logic [63:0] x_addr = '0, x_wdata = '0;
    logic [7:0]  x_wstrb = '0;
    logic [2:0]  x_size = '0;
    int          ar_hs_cnt = 0, aw_hs_cnt = 0, overlap_cnt = 0;

    function automatic logic [63:0] model_load(logic [63:0] rd, int off, int bytes, bit uns);
        logic [63:0] v;
        logic [63:0] mask;
        v = rd >> (8 * off);
        if (bytes == 8) return v;
        mask = (64'd1 << (8 * bytes)) - 64'd1;
        v = v & mask;
        if (!uns && v[8 * bytes - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [7:0] model_strb(int off, int bytes);
        logic [15:0] s;
        s = ((16'd1 << bytes) - 16'd1) << off;
        return s[7:0];
    endfunction

    // AXI slave: ready after a programmable wait, R/B one cycle after the request handshake(s).
    initial begin
        int ar_wait = 0, aw_wait = 0, w_wait = 0, r_cnt = 0;
        bit r_pend = 0, aw_got = 0, w_got = 0;
        bit hs_ar, hs_r, hs_aw, hs_w, hs_b;
        forever begin
            @(negedge clk);
            hs_ar = m_axi_arvalid && m_axi_arready;
            hs_r  = m_axi_rvalid  && m_axi_rready;
            hs_aw = m_axi_awvalid && m_axi_awready;
            hs_w  = m_axi_wvalid  && m_axi_wready;
            hs_b  = m_axi_bvalid  && m_axi_bready;
            if (m_axi_arvalid && m_axi_awvalid) overlap_cnt++;
            if (hs_ar) begin
                ar_hs_cnt++;
                check("araddr", m_axi_araddr, x_addr);
                check("arsize", m_axi_arsize, x_size);
                check("arlen_arburst_arid", {m_axi_arid, m_axi_arlen, m_axi_arburst}, {13'd0, 8'd0, 2'b01});
            end
            if (hs_aw) begin
                aw_hs_cnt++;
                check("awaddr", m_axi_awaddr, x_addr);
                check("awsize", m_axi_awsize, x_size);
                check("awlen_awburst_awid", {m_axi_awid, m_axi_awlen, m_axi_awburst}, {13'd0, 8'd0, 2'b01});
            end
            if (hs_w) begin
                check("wdata", m_axi_wdata, x_wdata);
                check("wstrb_wlast", {m_axi_wstrb, m_axi_wlast}, {x_wstrb, 1'b1});
            end
            @(posedge clk);
            #1;
            if (!reset) begin
                m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0;
                m_axi_rvalid = 0; m_axi_bvalid = 0;
                r_pend = 0; aw_got = 0; w_got = 0;
                ar_wait = 0; aw_wait = 0; w_wait = 0;
            end else begin
                if (hs_r) m_axi_rvalid = 0;
                if (hs_b) m_axi_bvalid = 0;
                if (hs_ar) begin r_pend = 1; r_cnt = sl_r_dly; end
                if (hs_aw) aw_got = 1;
                if (hs_w)  w_got = 1;
                if (r_pend) begin
                    if (r_cnt == 0) begin
                        m_axi_rvalid = 1; m_axi_rdata = sl_rdata;
                        m_axi_rresp = sl_rresp; m_axi_rlast = 1; r_pend = 0;
                    end else r_cnt--;
                end
                if (aw_got && w_got) begin
                    m_axi_bvalid = 1; m_axi_bresp = sl_bresp;
                    aw_got = 0; w_got = 0;
                end
                if (m_axi_arvalid) begin m_axi_arready = (ar_wait >= sl_ar_dly); ar_wait++; end
                else begin m_axi_arready = 0; ar_wait = 0; end
                if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= sl_aw_dly); aw_wait++; end
                else begin m_axi_awready = 0; aw_wait = 0; end
                if (m_axi_wvalid) begin m_axi_wready = (w_wait >= sl_w_dly); w_wait++; end
                else begin m_axi_wready = 0; w_wait = 0; end
            end
        end
    end

    // Monitor: every resp_valid pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                resp_cnt++;
                check("resp_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", resp_err, e.err);
                    check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
                end
            end
        end
    end

    task automatic wait_accept();
        bit accepted = 0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready) accepted = 1;
            @(posedge clk);
            #1;
            if (accepted) acc_cyc = cyc;
        end
        req_valid = 1'b0;
        check("accept_timeout", accepted, 1'b1);
    endtask

    task automatic drive_req(input bit w, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [1:0] size, input bit uns);
        req_valid = 1'b1; req_write = w; req_addr = addr;
        req_wdata = wdata; req_size = size; req_unsigned = uns;
    endtask

    task automatic do_op(input bit w, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input bit uns, input logic [63:0] rdata,
                         input logic [1:0] rresp, input logic [1:0] bresp,
                         input int ard, input int awd, input int wd, input int rd);
        exp_t e;
        int   off, bytes, start, bus0, slow;
        bit   trap, got;
        off   = int'(addr[2:0]);
        bytes = 1 << size;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (off % bytes) != 0;
`else
        trap = 1'b0;
`endif
        slow = (awd > wd) ? awd : wd;
        if (trap) begin
            e.rdata = '0; e.err = 1'b1; e.lat = 1;
        end else if (w) begin
            e.rdata = '0; e.err = (bresp != 2'b00); e.lat = 3 + slow;
        end else begin
            e.err = (rresp != 2'b00);
            e.rdata = e.err ? 64'd0 : model_load(rdata, off, bytes, uns);
            e.lat = 3 + ard + rd;
        end
        x_addr = addr; x_size = {1'b0, size};
        x_wdata = wdata << (8 * off); x_wstrb = model_strb(off, bytes);
        sl_rdata = rdata; sl_rresp = rresp; sl_bresp = bresp;
        sl_ar_dly = ard; sl_aw_dly = awd; sl_w_dly = wd; sl_r_dly = rd;
        exp_q.push_back(e);
        start = resp_cnt;
        bus0 = ar_hs_cnt + aw_hs_cnt;
        drive_req(w, addr, wdata, size, uns);
        wait_accept();
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (resp_cnt != start) got = 1;
        end
        check("resp_timeout", got, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("bus_txn_count", 64'(ar_hs_cnt + aw_hs_cnt - bus0), trap ? 64'd0 : 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        logic [63:0] a;
        logic [1:0]  sz;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", req_ready, 1'b0);
        check("reset_valids", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, resp_valid}, 6'd0);
        check("reset_resp", {resp_rdata, resp_err}, 65'd0);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_req_ready", req_ready, 1'b1);

        // Directed cases.
        do_op(0, 64'h1000, 0, 2'd3, 0, 64'h8877665544332211, 2'b00, 2'b00, 0, 0, 0, 0);
        do_op(0, 64'h1003, 0, 2'd0, 0, 64'h0000000080000000, 2'b00, 2'b00, 0, 0, 0, 0);
        do_op(0, 64'h1003, 0, 2'd0, 1, 64'h0000000080000000, 2'b00, 2'b00, 0, 0, 0, 0);
        do_op(1, 64'h2006, 64'hBEEF, 2'd1, 0, 0, 2'b00, 2'b00, 0, 2, 0, 0);
        do_op(1, 64'h3000, 64'h0123456789ABCDEF, 2'd3, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        do_op(1, 64'h3008, 64'h55AA, 2'd2, 0, 0, 2'b00, 2'b10, 0, 0, 1, 0);
        do_op(0, 64'h3010, 0, 2'd3, 0, 64'hDEADBEEFCAFEF00D, 2'b11, 2'b00, 0, 0, 0, 0);
        do_op(0, 64'h1002, 0, 2'd2, 0, 64'h1122334455667788, 2'b00, 2'b00, 0, 0, 0, 0);

        // Reset in the middle of a read: the slave holds R back so the DUT sits in RD_DATA.
        x_addr = 64'h4000; x_size = 3'd3; sl_ar_dly = 0; sl_r_dly = 8;
        drive_req(0, 64'h4000, 0, 2'd3, 0);
        wait_accept();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (m_axi_rready) seen = 1;
        end
        check("reach_rd_data", seen, 1'b1);
        reset = 1'b0;
        #1;
        check("midrst_arvalid_rready", {m_axi_arvalid, m_axi_rready}, 2'b00);
        check("midrst_req_ready", req_ready, 1'b0);
        check("midrst_other", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, resp_valid, resp_err}, 5'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_release_req_ready", req_ready, 1'b1);
        do_op(0, 64'h4008, 0, 2'd2, 1, 64'hF0E0D0C0B0A09080, 2'b00, 2'b00, 0, 0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            sz = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            do_op(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, sz, 1'($urandom_range(0, 1)),
                  {$urandom, $urandom},
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        check("ar_aw_overlap", 64'(overlap_cnt), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_axi.md
# lsu_axi

Load/store unit for the memory stage of the RISC-V core. Accepts one load or store per handshake from the execute stage: the ALU result is the address, rs2 is the store data. Runs a single-beat AXI transaction on the data-side read and write channels. Returns lane-aligned, sign- or zero-extended load data to the writeback mux.

## Interface
Parameters:
- ID_WIDTH, 13, AXI ID width; all IDs driven to 0
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 64, bus data width; fixed at 64 by the lane logic
- STRB_WIDTH, DATA_WIDTH/8, write strobe width

Ports:
- clk  input  1  core clock; everything sampled on the rising edge
- reset  input  1  asynchronous, active-low; asserting it (low) clears all state immediately
- req_valid  input  1  memory operation presented by execute
- req_ready  output  1  LSU can accept; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_addr  input  ADDR_WIDTH  byte address (ALU result)
- req_wdata  input  DATA_WIDTH  store data, right-justified
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double (funct3[1:0])
- req_unsigned  input  1  zero-extend the load (funct3[2])
- resp_valid  output  1  one-cycle pulse when the operation completes
- resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_err  output  1  bus error or misaligned access; valid with resp_valid
- AXI AR: m_axi_arid, araddr, arlen, arsize, arburst, arvalid (out); arready (in)
- AXI R: rdata, rresp, rlast, rvalid (in); rready (out)
- AXI AW: awid, awaddr, awlen, awsize, awburst, awvalid (out); awready (in)
- AXI W: wdata, wstrb, wlast, wvalid (out); wready (in)
- AXI B: bresp, bvalid (in); bready (out)

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: req_ready=1. On req_valid, latch addr, wdata, size, unsigned and write.
  - Load goes to RD_ADDR; store goes to WR_REQ.
- RD_ADDR:
  - arvalid=1 with araddr = latched addr, arlen=0, arsize=req_size, arburst=2'b01.
  - On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture the extended data.
  - resp_err = (rresp != 0).
  - Go to DONE.
- WR_REQ:
  - awvalid and wvalid both rise on entry.
  - Each drops independently after its own handshake.
  - Once both have completed, go to WR_RESP.
  - The two handshakes may complete in the same cycle.
- WR_RESP: bready=1. On bvalid, resp_err = (bresp != 0). Go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then return to IDLE.
- Lane rules, with off = addr[2:0]:
  - load data = rdata >> (8*off), truncated to 8/16/32/64 bits, then sign- or zero-extended.
  - wdata = req_wdata << (8*off).
  - wstrb = ((1<<(1<<size))-1) << off.
  - wlast=1.
- A load that errors returns resp_rdata=0.
- The LSU never asserts arvalid and awvalid together; only one transaction is outstanding at a time.

## Timing
- Reset values: all valids, rready, bready and resp_valid are 0; resp_rdata=0; resp_err=0; state is IDLE.
- req_ready returns to 1 after reset is released.
- Latency: accept in cycle 0; arvalid/awvalid first high in cycle 1.
  - With zero-wait slave responses, a load gives resp_valid in cycle 4 and a store in cycle 4.
- AXI VALID outputs stay asserted and stable until their READY, as the AXI protocol requires.
- Reset asserted mid-transaction:
  - All outputs return to reset values asynchronously.
  - The transaction is abandoned; the bus resets with the core.
- A req_valid arriving while not in IDLE is ignored; the requester holds it until req_ready.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A request with addr not aligned to its size goes straight from IDLE to DONE.
  - It issues no bus traffic and completes with resp_err=1 and resp_rdata=0, in cycle 2.
- Undefined: addr[2:0] is used as given.
  - Accesses that cross the 8-byte boundary get their strobe and shift truncated at bit 63; no error is reported.

## Structure
- Shared package lsu_pkg holds:
  - the size enum (SZ_B, SZ_H, SZ_W, SZ_D)
  - the state enum
  - AXI burst and response constants (BURST_INCR=2'b01, RESP_OKAY=2'b00)
- Sub-module lsu_lane_align (combinational):
  - store side: wdata shift and wstrb generation
  - load side: rdata extraction and extension
- The FSM and AXI registers stay in lsu_axi.

## Test plan
- Load doubleword: addr 0x1000, rdata 0x8877665544332211 -> resp_rdata 0x8877665544332211, resp_err=0; arsize=3, arlen=0.
- Signed byte load: addr 0x1003, rdata 0x00000000_80000000 → resp_rdata 0xFFFFFFFFFFFFFF80. Same access with req_unsigned=1 → 0x80.
- Half store: addr 0x2006, req_wdata 0xBEEF -> wdata 0xBEEF_0000_0000_0000, wstrb 0xC0. Test with wready asserted two cycles before awready; exactly one resp_valid.
- Error: bresp=2'b10 on a store -> resp_err=1. rresp=2'b11 on a load -> resp_err=1, resp_rdata=0.
- Reset mid-read: reset driven low while in RD_DATA → arvalid=0, rready=0, req_ready=0 at once. After release: req_ready=1, and the next load completes normally.
- Misaligned word load at 0x1002:
  - with LSU_MISALIGN_TRAP_EN: no arvalid, resp_err=1 in cycle 2.
  - without it: bus read issued, resp_err=0.
